// File: rtl/tx_gnt_dispatch.sv
// tx_gnt_dispatch: turns a one-hot arbiter grant into one PMTU-sized packet of beats.
// Define TX_BYTE_CNT_EN to build the per-channel transmitted byte counters.
`timescale 1ns/1ps
module tx_gnt_dispatch #(
  parameter int unsigned BEAT_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt_val,
  input  logic        gnt0,
  input  logic        gnt1,
  input  logic        gnt2,
  input  logic        gnt3,
  output logic        gnt_busy,
  input  logic [2:0]  pmtu0,
  input  logic [2:0]  pmtu1,
  input  logic [2:0]  pmtu2,
  input  logic [2:0]  pmtu3,
  output logic        tx_val,
  input  logic        tx_rdy,
  output logic [1:0]  tx_ch,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [12:0] tx_len,
  output logic        gnt_err
`ifdef TX_BYTE_CNT_EN
  ,
  output logic [31:0] byte_cnt0,
  output logic [31:0] byte_cnt1,
  output logic [31:0] byte_cnt2,
  output logic [31:0] byte_cnt3
`endif
);

  localparam int unsigned LEN_W      = 13;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned BC_W       = 32;
  localparam int unsigned BEAT_SHIFT = (BEAT_BYTES == 128) ? 7 : 6;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       ch_q;
  logic [LEN_W-1:0] len_q;
  logic             sop_q;
  logic             eop_q;
  logic             err_q;

  logic [3:0]       gnt_vec_d;
  logic             onehot_d;
  logic [1:0]       gnt_ch_d;
  logic [2:0]       pmtu_sel_d;
  logic [2:0]       code_d;
  logic [LEN_W-1:0] len_d;
  logic [CNT_W-1:0] beats_d;
  logic             beat_c;

  // Decode the grant and size the packet of the granted channel.
  always_comb begin
    gnt_vec_d = {gnt3, gnt2, gnt1, gnt0};
    onehot_d  = $onehot(gnt_vec_d);
    gnt_ch_d  = {gnt2 | gnt3, gnt1 | gnt3};
    case (gnt_ch_d)
      2'd0:    pmtu_sel_d = pmtu0;
      2'd1:    pmtu_sel_d = pmtu1;
      2'd2:    pmtu_sel_d = pmtu2;
      default: pmtu_sel_d = pmtu3;
    endcase
    code_d  = (pmtu_sel_d > 3'd4) ? 3'd4 : pmtu_sel_d;
    len_d   = LEN_W'(13'd256 << code_d);
    beats_d = CNT_W'(len_d >> BEAT_SHIFT);
    beat_c  = (state_q == SEND) && tx_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      len_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_val) begin
            if (onehot_d) begin
              state_q <= SEND;
              ch_q    <= gnt_ch_d;
              len_q   <= len_d;
              cnt_q   <= beats_d;
              sop_q   <= 1'b1;
              eop_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          // Packets are at least two beats long, so eop is never set at acceptance.
          if (tx_rdy) begin
            cnt_q <= cnt_q - CNT_W'(1);
            sop_q <= 1'b0;
            if (eop_q) begin
              state_q <= IDLE;
              eop_q   <= 1'b0;
            end else begin
              eop_q <= (cnt_q == CNT_W'(2));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_busy = (state_q == SEND);
  assign tx_val   = (state_q == SEND);
  assign tx_ch    = ch_q;
  assign tx_len   = len_q;
  assign tx_sop   = sop_q;
  assign tx_eop   = eop_q;
  assign gnt_err  = err_q;

`ifdef TX_BYTE_CNT_EN
  logic [BC_W-1:0] bcnt_q [4];

  // Byte totals wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) bcnt_q[i] <= '0;
    end else if (beat_c) begin
      bcnt_q[ch_q] <= bcnt_q[ch_q] + BC_W'(BEAT_BYTES);
    end
  end

  assign byte_cnt0 = bcnt_q[0];
  assign byte_cnt1 = bcnt_q[1];
  assign byte_cnt2 = bcnt_q[2];
  assign byte_cnt3 = bcnt_q[3];
`endif

endmodule

// File: tb/tb_tx_gnt_dispatch.sv
// Directed bench for tx_gnt_dispatch: a cycle table for handshake/grant decode plus
// hand-written multi-cycle sequences. Byte counters are checked when TX_BYTE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_tx_gnt_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt_val, gnt0, gnt1, gnt2, gnt3;
  logic        gnt_busy;
  logic [2:0]  pmtu0, pmtu1, pmtu2, pmtu3;
  logic        tx_val, tx_rdy, tx_sop, tx_eop, gnt_err;
  logic [1:0]  tx_ch;
  logic [12:0] tx_len;
`ifdef TX_BYTE_CNT_EN
  logic [31:0] byte_cnt0, byte_cnt1, byte_cnt2, byte_cnt3;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_gnt_dispatch #(.BEAT_BYTES(64)) dut (
    .clk(clk), .rst(rst),
    .gnt_val(gnt_val), .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
    .gnt_busy(gnt_busy),
    .pmtu0(pmtu0), .pmtu1(pmtu1), .pmtu2(pmtu2), .pmtu3(pmtu3),
    .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_ch(tx_ch),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_len(tx_len),
    .gnt_err(gnt_err)
`ifdef TX_BYTE_CNT_EN
    ,
    .byte_cnt0(byte_cnt0), .byte_cnt1(byte_cnt1),
    .byte_cnt2(byte_cnt2), .byte_cnt3(byte_cnt3)
`endif
  );

  typedef struct {
    logic        gv;
    logic [3:0]  g;
    logic        rdy;
    logic        busy;
    logic        val;
    logic        sop;
    logic        eop;
    logic        err;
    logic [1:0]  ch;
    logic [12:0] len;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_gnt(input logic gv, input logic [3:0] g);
    gnt_val = gv;
    {gnt3, gnt2, gnt1, gnt0} = g;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " val"}, 32'(tx_val), 0);
    chk({tag, " busy"}, 32'(gnt_busy), 0);
    chk({tag, " err"}, 32'(gnt_err), 0);
  endtask

  // Walk one packet with tx_rdy=1, starting at the negedge that shows its first beat.
  // pulse_at>0 fires a valid ch2 grant and changes pmtu1 during that beat.
  task automatic collect(input logic [1:0] ch, input logic [12:0] len,
                         input int beats, input int pulse_at);
    for (int b = 1; b <= beats; b++) begin
      if (pulse_at != 0 && b == pulse_at) begin
        set_gnt(1'b1, 4'b0100);
        pmtu1 = 3'd0;
      end else if (pulse_at != 0 && b == pulse_at + 1) begin
        set_gnt(1'b0, 4'b0000);
      end
      chk($sformatf("ch%0d b%0d val", ch, b), 32'(tx_val), 1);
      chk($sformatf("ch%0d b%0d ch", ch, b), 32'(tx_ch), 32'(ch));
      chk($sformatf("ch%0d b%0d len", ch, b), 32'(tx_len), 32'(len));
      chk($sformatf("ch%0d b%0d sop", ch, b), 32'(tx_sop), 32'(b == 1));
      chk($sformatf("ch%0d b%0d eop", ch, b), 32'(tx_eop), 32'(b == beats));
      chk($sformatf("ch%0d b%0d err", ch, b), 32'(gnt_err), 0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Table starts in IDLE with pmtu0=256B: backpressured 4-beat packet, then malformed grants.
    vt[0]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[3]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 13'd256};
    vt[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 13'd256};
    vt[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'd256};
    vt[9]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 13'd0};
    vt[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'd0};
    vt[11] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 13'd0};
    vt[12] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 13'd0};
    vt[13] = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'd0};

    rst = 1'b1;
    set_gnt(1'b0, 4'b0000);
    tx_rdy = 1'b0;
    pmtu0 = 3'd0; pmtu1 = 3'd3; pmtu2 = 3'd2; pmtu3 = 3'd4;
    @(negedge clk);
    chk_idle("rst");
    chk("rst sop", 32'(tx_sop), 0);
    chk("rst eop", 32'(tx_eop), 0);
    chk("rst ch", 32'(tx_ch), 0);
    chk("rst len", 32'(tx_len), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      set_gnt(vt[i].gv, vt[i].g);
      tx_rdy = vt[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", i), 32'(gnt_busy), 32'(vt[i].busy));
      chk($sformatf("v%0d val", i), 32'(tx_val), 32'(vt[i].val));
      chk($sformatf("v%0d sop", i), 32'(tx_sop), 32'(vt[i].sop));
      chk($sformatf("v%0d eop", i), 32'(tx_eop), 32'(vt[i].eop));
      chk($sformatf("v%0d err", i), 32'(gnt_err), 32'(vt[i].err));
      if (vt[i].val) begin
        chk($sformatf("v%0d ch", i), 32'(tx_ch), 32'(vt[i].ch));
        chk($sformatf("v%0d len", i), 32'(tx_len), 32'(vt[i].len));
      end
      @(negedge clk);
    end
    set_gnt(1'b0, 4'b0000);

    // Single 1024B grant on ch2: 16 beats, idle on the 17th cycle.
    tx_rdy = 1'b1;
    set_gnt(1'b1, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    set_gnt(1'b0, 4'b0000);
    collect(2'd2, 13'd1024, 16, 0);
    chk_idle("single c17");

    // Reset during beat 5 of a 4096B packet; grants are blocked while rst is high.
    set_gnt(1'b1, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    set_gnt(1'b0, 4'b0000);
    for (int b = 1; b <= 4; b++) begin
      chk($sformatf("pre-rst b%0d val", b), 32'(tx_val), 1);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst sop", 32'(tx_sop), 0);
    chk("midrst eop", 32'(tx_eop), 0);
    chk("midrst ch", 32'(tx_ch), 0);
    chk("midrst len", 32'(tx_len), 0);
`ifdef TX_BYTE_CNT_EN
    chk("midrst bc3", byte_cnt3, 0);
`endif
    set_gnt(1'b1, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    chk_idle("grant in rst");
    set_gnt(1'b0, 4'b0000);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_idle($sformatf("postrst c%0d", c));
    end

    // Back-to-back: ch3 4096B, grant for ch0 held during it, accepted in the single idle cycle.
    set_gnt(1'b1, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    set_gnt(1'b1, 4'b0001);
    collect(2'd3, 13'd4096, 64, 0);
    chk_idle("b2b gap");
    @(posedge clk);
    @(negedge clk);
    set_gnt(1'b0, 4'b0000);
    collect(2'd0, 13'd256, 4, 0);
    chk_idle("b2b end");
`ifdef TX_BYTE_CNT_EN
    chk("b2b byte_cnt3", byte_cnt3, 32'd4096);
    chk("b2b byte_cnt0", byte_cnt0, 32'd256);
    chk("b2b byte_cnt1", byte_cnt1, 32'd0);
`endif

    // Grant pulsed mid-packet and pmtu1 changed: no new packet, length stays 2048.
    set_gnt(1'b1, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    set_gnt(1'b0, 4'b0000);
    collect(2'd1, 13'd2048, 32, 3);
    for (int c = 0; c < 4; c++) begin
      chk_idle($sformatf("ign c%0d", c));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
